// File: rtl/motor_pkg.sv
// Shared definitions for the motor power scheduler: drive codes, slot states, round-robin helper.
package motor_pkg;

  localparam int N_MOTORS = 4;

  localparam logic [1:0] SEL_OFF = 2'b00;
  localparam logic [1:0] SEL_FWD = 2'b01;
  localparam logic [1:0] SEL_REV = 2'b10;
  localparam logic [1:0] SEL_ILL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RUN  = 2'd2
  } slot_state_t;

  // Returns {found, index} of the first set bit at ptr, ptr+1, ... (mod 4).
  function automatic logic [2:0] rr_pick(input logic [3:0] vec, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (vec[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

endpackage

// File: rtl/motor_slot.sv
// One motor's scheduling slot: state, slice timer and registered drive command.
//   state   | meaning
//   ST_IDLE | no valid request, motor off
//   ST_WAIT | requesting, not yet holding a power slot
//   ST_RUN  | holding a slot, sel follows the request
module motor_slot
  import motor_pkg::*;
#(
  parameter int SLICE = 1024,
  parameter int CNT_W = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       grant_pulse,
  input  logic       revoke_pulse,
  output logic       waiting,
  output logic       running,
  output logic       run_next,
  output logic       slice_zero,
  output logic [1:0] sel
);

  slot_state_t      state, state_next;
  logic [CNT_W-1:0] slice_cnt, slice_next;
  logic [1:0]       sel_next;
  logic             req_on;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      slice_cnt <= '0;
      sel       <= SEL_OFF;
    end else begin
      state     <= state_next;
      slice_cnt <= slice_next;
      sel       <= sel_next;
    end
  end

  always_comb begin
    state_next = state;
    slice_next = slice_cnt;
    req_on     = (req == SEL_FWD) || (req == SEL_REV);
    case (state)
      ST_IDLE: if (req_on) state_next = ST_WAIT;
      ST_WAIT: begin
        if (!req_on)          state_next = ST_IDLE;
        else if (grant_pulse) state_next = ST_RUN;
      end
      ST_RUN: begin
        // A request drop wins over a simultaneous revoke: the motor is released, not parked.
        if (!req_on)           state_next = ST_IDLE;
        else if (revoke_pulse) state_next = ST_WAIT;
      end
      default: state_next = ST_IDLE;
    endcase
    if (grant_pulse)
      slice_next = CNT_W'(SLICE - 1);
    else if (state == ST_RUN && slice_cnt != '0)
      slice_next = slice_cnt - CNT_W'(1);
    sel_next   = (state_next == ST_RUN) ? req : SEL_OFF;
    waiting    = (state == ST_WAIT);
    running    = (state == ST_RUN);
    run_next   = (state_next == ST_RUN);
    slice_zero = (slice_cnt == '0);
  end

endmodule

// File: rtl/motor_power_scheduler.sv
// Power-budget scheduler: staggered round-robin grants of at most MAX_ACTIVE motors with slice pre-emption.
module motor_power_scheduler
  import motor_pkg::*;
#(
  parameter int MAX_ACTIVE = 2,
  parameter int START_GAP  = 16,
  parameter int SLICE      = 1024,
  parameter int CNT_W      = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req_sel,
  output logic [7:0] sel,
  output logic [3:0] grant,
  output logic [3:0] waiting,
  output logic [2:0] active_cnt
);

  logic [3:0]       run_next, slice_zero, grant_pulse, revoke_pulse;
  logic [CNT_W-1:0] gap_cnt;
  logic [1:0]       rr_ptr;
  logic [2:0]       g_pick, r_pick;
  logic             do_grant, do_revoke;

  // Grant and revoke both look at the registered active_cnt, so they are mutually exclusive.
  always_comb begin
    g_pick       = rr_pick(waiting, rr_ptr);
    r_pick       = rr_pick(grant & slice_zero, rr_ptr);
    do_grant     = (gap_cnt == '0) && (active_cnt < 3'(MAX_ACTIVE)) && g_pick[2];
    do_revoke    = (active_cnt == 3'(MAX_ACTIVE)) && (|waiting) && r_pick[2];
    grant_pulse  = do_grant  ? (4'b0001 << g_pick[1:0]) : 4'b0000;
    revoke_pulse = do_revoke ? (4'b0001 << r_pick[1:0]) : 4'b0000;
  end

  for (genvar i = 0; i < N_MOTORS; i++) begin : g_slot
    motor_slot #(
      .SLICE (SLICE),
      .CNT_W (CNT_W)
    ) u_slot (
      .clk          (clk),
      .rst          (rst),
      .req          (req_sel[2*i +: 2]),
      .grant_pulse  (grant_pulse[i]),
      .revoke_pulse (revoke_pulse[i]),
      .waiting      (waiting[i]),
      .running      (grant[i]),
      .run_next     (run_next[i]),
      .slice_zero   (slice_zero[i]),
      .sel          (sel[2*i +: 2])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gap_cnt    <= '0;
      rr_ptr     <= 2'd0;
      active_cnt <= 3'd0;
    end else begin
      if (do_grant) begin
        gap_cnt <= CNT_W'(START_GAP - 1);
        rr_ptr  <= g_pick[1:0] + 2'd1;
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - CNT_W'(1);
      end
      active_cnt <= 3'($countones(run_next));
    end
  end

endmodule
